// File: rtl/alu_rr_arbiter_pkg.sv
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Shared widths, ALU opcodes and result-register states for
//                the round-robin ALU arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

    localparam int ID_W   = 3;
    localparam int DATA_W = 4;
    localparam int RES_W  = 5;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
//  Module      : alu_core
//  Description : Combinational 4-bit ALU: SRA, SRL, SUB with borrow, ADD
//                with carry; 5-bit result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        c,
    input  logic [1:0]        op,
    output logic [RES_W-1:0]  result
);

    logic [DATA_W-1:0] w_sra;

    assign w_sra = $signed(a) >>> c;

    always_comb begin
        result = '0;
        case (op)
            OP_SRA:  result = {1'b0, w_sra};
            OP_SRL:  result = {1'b0, a >> c};
            // Bit 4 of the 5-bit difference is the unsigned borrow.
            OP_SUB:  result = {1'b0, a} - {1'b0, b};
            OP_ADD:  result = {1'b0, a} + {1'b0, b};
            default: result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
// ============================================================================
//  Module      : alu_rr_arbiter
//  Description : Round-robin arbiter sharing one ALU between NREQ requesters,
//                with a registered valid/ready result. Optional per-requester
//                grant counters when ALU_ARB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [4*NREQ-1:0]      req_a,
    input  logic [4*NREQ-1:0]      req_b,
    input  logic [2*NREQ-1:0]      req_c,
    input  logic [2*NREQ-1:0]      req_op,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [RES_W-1:0]       res_data,
    output logic [ID_W-1:0]        res_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [8*NREQ-1:0]      grant_cnt
`endif
);

    arb_state_t          r_state;
    arb_state_t          w_stateNext;
    logic [ID_W-1:0]     r_last;
    logic [RES_W-1:0]    r_resData;
    logic [ID_W-1:0]     r_resId;

    logic                w_acceptEn;
    logic                w_grantValid;
    logic [ID_W-1:0]     w_grantIdx;
    logic                w_accept;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [1:0]          w_c;
    logic [1:0]          w_op;
    logic [RES_W-1:0]    w_aluRes;

    assign w_acceptEn = (r_state == ST_EMPTY) || res_ready;
    assign w_accept   = w_acceptEn && w_grantValid;

    // Two passes: indices above last first, then wrap to indices up to last.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_grantValid && req_valid[i] && (ID_W'(i) > r_last)) begin
                w_grantValid = 1'b1;
                w_grantIdx   = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_grantValid && req_valid[i] && (ID_W'(i) <= r_last)) begin
                w_grantValid = 1'b1;
                w_grantIdx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_c  = '0;
        w_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == w_grantIdx) begin
                w_a  = req_a[4*i +: 4];
                w_b  = req_b[4*i +: 4];
                w_c  = req_c[2*i +: 2];
                w_op = req_op[2*i +: 2];
            end
        end
    end

    assign req_ready = w_accept ? (NREQ'(1) << w_grantIdx) : '0;

    alu_core u_alu_core (
        .a      (w_a),
        .b      (w_b),
        .c      (w_c),
        .op     (w_op),
        .result (w_aluRes)
    );

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_stateNext = ST_FULL;
            ST_FULL:  if (res_ready && !w_accept) w_stateNext = ST_EMPTY;
            default:  w_stateNext = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_last    <= ID_W'(NREQ - 1);
            r_resData <= '0;
            r_resId   <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_last    <= w_grantIdx;
                r_resData <= w_aluRes;
                r_resId   <= w_grantIdx;
            end
        end
    end

    assign res_valid = (r_state == ST_FULL);
    assign res_data  = r_resData;
    assign res_id    = r_resId;

`ifdef ALU_ARB_STATS_EN
    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_stats
            logic [7:0] r_cnt;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (req_valid[g] && req_ready[g] && (r_cnt != 8'hFF)) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
            assign grant_cnt[8*g +: 8] = r_cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one 4-bit ALU datapath between NREQ requesters using round-robin arbitration.
- Each requester presents operands and an opcode with a valid/ready handshake.
- The winning request is executed on the ALU and the result is registered with the requester ID, behind a valid/ready output handshake.
- Sits between the operand-issuing control logic and the shared ALU; it is the only block that drives the ALU operands.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i presents an operation.
- req_ready  output  NREQ  bit i: requester i's operation is accepted this cycle.
- req_a  input  4*NREQ  operand A; requester i uses bits [4i+3:4i].
- req_b  input  4*NREQ  operand B; requester i uses bits [4i+3:4i].
- req_c  input  2*NREQ  shift amount; requester i uses bits [2i+1:2i].
- req_op  input  2*NREQ  opcode; requester i uses bits [2i+1:2i].
- res_valid  output  1  registered result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  5  ALU result.
- res_id  output  3  index of the requester that produced res_data.

Behaviour:
- Reset:
  - res_valid=0, res_data=0, res_id=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - Reset mid-hold discards the pending result.
- accept_en = !res_valid || res_ready. A full-throughput drain and refill in the same cycle is allowed.
- Grant selection:
  - Scan requesters starting at (last+1) mod NREQ and wrap around.
  - The first i with req_valid[i]=1 wins.
  - This is combinational from req_valid and last.
- Ready: req_ready[i]=1 only for the winner and only when accept_en=1; at most one bit is set.
- Requester rule: a requester must not make req_valid depend on req_ready. Once raised, req_valid and the operands hold until accepted.
- On accept (req_valid[i] && req_ready[i]):
  - Next edge: res_valid=1, res_data=ALU(operands of i), res_id=i, last=i.
  - Latency is 1 cycle from accept to res_valid.
- Drain: when res_valid && res_ready and there is no new accept, res_valid goes to 0 next edge. res_data and res_id keep their last values.
- Stall: while res_valid && !res_ready, res_data and res_id are stable, all req_ready=0, and last is unchanged.
- No valid requests while accept_en=1: no state change except the drain.
- ALU ops (5-bit result):
  - 00: arithmetic right shift of signed A by C; [3:0] is sign-filled, bit4=0.
  - 01: logical right shift of A by C, zero-filled; bit4=0.
  - 10: A-B modulo 32; bit4=1 when A<B unsigned.
  - 11: A+B with carry in bit4.
- States: EMPTY (res_valid=0) and FULL (res_valid=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on res_ready with no accept.
  - FULL->FULL on stall, or on drain with a refill.

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - Adds output grant_cnt, 8*NREQ wide.
  - Holds one 8-bit counter per requester, incremented on each accept and saturating at 255.
  - All counters are cleared by reset.
- Undefined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg holds:
  - opcode constants OP_SRA=2'b00, OP_SRL=2'b01, OP_SUB=2'b10, OP_ADD=2'b11;
  - ID_W=3, DATA_W=4, RES_W=5.
- Sub-module alu_core: purely combinational ALU (a, b, c, op -> 5-bit result), instantiated once.
- Arbiter, pointer and output register live in the top module.

Test Plan:
- Single request, output not stalled: requester 0 with a=4'hA, b=4'h7, op=11, res_ready=1 -> accepted in 1 cycle; next cycle res_valid=1, res_data=5'h11, res_id=0.
- Op coverage on requester 0:
  - a=4'b1000, c=2, op=00 -> 5'b01110.
  - op=01 -> 5'b00010.
  - a=3, b=5, op=10 -> 5'b11110.
- Round-robin: requesters 0 and 1 both valid continuously, res_ready=1 -> grants alternate 0,1,0,1; one result per cycle with res_id alternating.
- Backpressure: res_ready=0 for 3 cycles with 2 requesters valid -> req_ready=0 throughout and res_data/res_id stable. On res_ready=1, the next grant goes to the requester after last, in the same cycle as the drain.
- Reset while FULL and stalled -> next cycle res_valid=0, res_data=0; the first grant after reset goes to requester 0.
- ALU_ARB_STATS_EN defined: 300 accepts from requester 1 -> grant_cnt[15:8]=255 and grant_cnt[7:0]=0.
